// File: rtl/dot_board_render_if.sv
// ============================================================================
// Module      : dot_board_render_if
// Description : Board-update handshake bundle between the game logic and the
//               dot-matrix renderer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dot_board_render_if;
  logic [17:0] board;
  logic        shift_right;
  logic        turn_o;
  logic [3:0]  cursor;
  logic        board_valid;
  logic        board_ready;

  modport master (
    output board, shift_right, turn_o, cursor, board_valid,
    input  board_ready
  );

  modport slave (
    input  board, shift_right, turn_o, cursor, board_valid,
    output board_ready
  );
endinterface

`default_nettype wire

// File: rtl/dot_board_render.sv
// ============================================================================
// Module      : dot_board_render
// Description : Row-scanning 10x14 dot-matrix driver for the tic-tac-toe board,
//               with a double-buffered board update applied at frame wrap.
//               Optional feature macro: DOT_CURSOR_BLINK_EN (cursor cell blink).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_board_render #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst,
  dot_board_render_if.slave  bus,
  output logic               frame_start,
  output logic [9:0]         dot_row,
  output logic [13:0]        dot_col
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         row_q, row_d;
  logic               tick, wrap, use_pend, capture;

  logic               pend_full_q;
  logic [17:0]        pend_board_q, shd_board_q, src_board;
  logic               pend_shr_q, shd_shr_q, src_shr;
  logic               pend_turn_q, shd_turn_q, src_turn;
  logic [8:0]         blank;

  logic               frame_start_q;
  logic [9:0]         dot_row_q;
  logic [13:0]        dot_col_q;

`ifdef DOT_CURSOR_BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [3:0]         pend_cur_q, shd_cur_q, src_cur;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               phase_q, phase_d;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_cursor;
  assign unused_cursor = ^bus.cursor;
`endif

  // Builds one row of column data; cbase is the index of the leftmost cell in the row.
  function automatic logic [13:0] render_row(
    input logic [3:0]  row,
    input logic [17:0] brd,
    input logic        shr,
    input logic        trn,
    input logic [8:0]  blk
  );
    logic [8:0] line;
    logic [1:0] pr;
    logic [3:0] cbase;
    logic [1:0] code;
    line  = '0;
    pr    = '0;
    cbase = '0;
    code  = '0;
    if (row == 4'd9) begin
      line = trn ? 9'h007 : 9'h1C0;
    end else begin
      pr    = 2'(row % 4'd3);
      cbase = 4'(row - {2'b00, pr});
      for (int k = 0; k < 3; k++) begin
        code = brd[2*(int'(cbase)+k) +: 2];
        if (blk[int'(cbase)+k]) code = 2'd0;
        case (code)
          2'd1:    line[3*k +: 3] = (pr == 2'd1) ? 3'b010 : 3'b101;
          2'd2:    line[3*k +: 3] = (pr == 2'd1) ? 3'b101 : 3'b111;
          default: line[3*k +: 3] = 3'b000;
        endcase
      end
    end
    return shr ? {line, 5'b0} : {5'b0, line};
  endfunction

  always_comb begin
    tick     = (presc_q == PRESC_W'(SCAN_DIV - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;
    wrap     = tick && (row_q == 4'd9);
    row_d    = row_q;
    if (tick) row_d = wrap ? 4'd0 : row_q + 4'd1;
    capture  = bus.board_valid && !pend_full_q;
    // Row 0 of a new frame must already show the pending update being committed on this edge.
    use_pend = wrap && pend_full_q;
    src_board = use_pend ? pend_board_q : shd_board_q;
    src_shr   = use_pend ? pend_shr_q   : shd_shr_q;
    src_turn  = use_pend ? pend_turn_q  : shd_turn_q;
    blank     = '0;
`ifdef DOT_CURSOR_BLINK_EN
    src_cur = use_pend ? pend_cur_q : shd_cur_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end
    if (phase_d && (src_cur >= 4'd1) && (src_cur <= 4'd9))
      blank = 9'(9'd1 << (src_cur - 4'd1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      row_q         <= 4'd9;
      frame_start_q <= 1'b0;
      dot_row_q     <= '0;
      dot_col_q     <= '0;
      pend_full_q   <= 1'b0;
      pend_board_q  <= '0;
      pend_shr_q    <= 1'b0;
      pend_turn_q   <= 1'b0;
      shd_board_q   <= '0;
      shd_shr_q     <= 1'b0;
      shd_turn_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      row_q         <= row_d;
      frame_start_q <= wrap;
      if (tick) begin
        dot_row_q <= 10'd1 << row_d;
        dot_col_q <= render_row(row_d, src_board, src_shr, src_turn, blank);
      end
      if (use_pend) begin
        shd_board_q <= pend_board_q;
        shd_shr_q   <= pend_shr_q;
        shd_turn_q  <= pend_turn_q;
        pend_full_q <= 1'b0;
      end else if (capture) begin
        pend_board_q <= bus.board;
        pend_shr_q   <= bus.shift_right;
        pend_turn_q  <= bus.turn_o;
        pend_full_q  <= 1'b1;
      end
    end
  end

`ifdef DOT_CURSOR_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cur_q <= '0;
      shd_cur_q  <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      if (use_pend)     shd_cur_q  <= pend_cur_q;
      else if (capture) pend_cur_q <= bus.cursor;
    end
  end
`endif

  assign bus.board_ready = ~pend_full_q;
  assign frame_start     = frame_start_q;
  assign dot_row         = dot_row_q;
  assign dot_col         = dot_col_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_board_render.sv
// ============================================================================
// Module      : tb_dot_board_render
// Description : Scoreboard bench for dot_board_render (SCAN_DIV=4, BLINK_FRAMES=2);
//               covers blink behaviour when DOT_CURSOR_BLINK_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dot_board_render;
  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [9:0]  dot_row;
  logic [13:0] dot_col;

  dot_board_render_if bus();

  dot_board_render #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .frame_start (frame_start),
    .dot_row     (dot_row),
    .dot_col     (dot_col)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          frame_no = 0;
  logic [23:0] exp_q[$];
  logic [9:0]  prev_row = '0;
  int          fs_cnt = 0;
  bit          fs_have = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected column data computed pixel by pixel from the glyph definitions.
  function automatic logic [13:0] exp_col(input int r, input logic [17:0] b,
                                          input bit shr, input bit trn, input int blank_cell);
    logic [13:0] v;
    logic [1:0]  code;
    int off, l, c, p, q;
    v   = '0;
    off = shr ? 5 : 0;
    for (int j = 0; j < 14; j++) begin
      l = j - off;
      if (l >= 0 && l <= 8) begin
        if (r == 9) begin
          v[j] = trn ? (l < 3) : (l >= 6);
        end else begin
          c = (r / 3) * 3 + l / 3;
          p = r % 3;
          q = l % 3;
          code = b[2*c +: 2];
          if (c == blank_cell) code = 2'd0;
          case (code)
            2'd1:    v[j] = (p == 1) ? (q == 1) : (q != 1);
            2'd2:    v[j] = (p == 1) ? (q != 1) : 1'b1;
            default: v[j] = 1'b0;
          endcase
        end
      end
    end
    return v;
  endfunction

  task automatic push_frame(input logic [17:0] b, input bit shr, input bit trn, input int blank_cell);
    for (int r = 0; r < 10; r++)
      exp_q.push_back({10'(1 << r), exp_col(r, b, shr, trn, blank_cell)});
  endtask

  function automatic int blank_for(input int n);
`ifdef DOT_CURSOR_BLINK_EN
    return (((n / BF) % 2) == 1) ? 4 : -1;
`else
    return (n < 0) ? 0 : -1;
`endif
  endfunction

  task automatic wait_frame(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_start) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    check_eq("frame_seen", 32'(found), 32'd1);
    if (found) frame_no++;
  endtask

  task automatic offer(input logic [17:0] b, input bit shr, input bit trn, input logic [3:0] cur);
    bus.board       = b;
    bus.shift_right = shr;
    bus.turn_o      = trn;
    bus.cursor      = cur;
    bus.board_valid = 1'b1;
    @(negedge clk);
    bus.board_valid = 1'b0;
  endtask

  // Scoreboard consumer and frame-period monitor.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst) begin
      prev_row = '0;
      fs_have  = 1'b0;
      fs_cnt   = 0;
    end else begin
      if (dot_row != prev_row) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_row", 32'(dot_row), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("dot_row", 32'(dot_row), 32'(e[23:14]));
          check_eq("dot_col", 32'(dot_col), 32'(e[13:0]));
        end
      end
      prev_row = dot_row;
      if (fs_have) fs_cnt++;
      if (frame_start) begin
        if (fs_have) check_eq("frame_period", 32'(fs_cnt), 32'(10 * SD));
        fs_cnt  = 0;
        fs_have = 1'b1;
      end
    end
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.board       = '0;
    bus.shift_right = 1'b0;
    bus.turn_o      = 1'b0;
    bus.cursor      = '0;
    bus.board_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_dot_row", 32'(dot_row), 32'd0);
    check_eq("rst_dot_col", 32'(dot_col), 32'd0);
    check_eq("rst_ready", 32'(bus.board_ready), 32'd1);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);

    // Frame 1 and 2: empty board, X to move.
    push_frame('0, 1'b0, 1'b0, -1);
    rst = 1'b0;
    wait_frame(n);
    check_eq("first_tick", 32'(n), 32'(SD));
    push_frame('0, 1'b0, 1'b0, -1);
    wait_frame(n);

    // Mid-frame update, then a second offer while busy which must be ignored.
    push_frame(18'h00001, 1'b0, 1'b0, -1);
    repeat (12) @(negedge clk);
    offer(18'h00001, 1'b0, 1'b0, 4'd0);
    check_eq("ready_drop", 32'(bus.board_ready), 32'd0);
    bus.board       = 18'h10000;
    bus.board_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.board_valid = 1'b0;
    repeat (21) @(negedge clk);
    check_eq("ready_hold", 32'(bus.board_ready), 32'd0);
    wait_frame(n);
    check_eq("wrap_align", 32'(n), 32'd1);
    check_eq("ready_rise", 32'(bus.board_ready), 32'd1);

    // Offer on the wrap tick itself: applied one frame later.
    push_frame(18'h00001, 1'b0, 1'b0, -1);
    repeat (39) @(negedge clk);
    bus.board       = 18'h20000;
    bus.shift_right = 1'b1;
    bus.turn_o      = 1'b1;
    bus.cursor      = 4'd0;
    bus.board_valid = 1'b1;
    @(negedge clk);
    bus.board_valid = 1'b0;
    check_eq("wrap_tick_fs", 32'(frame_start), 32'd1);
    if (frame_start) frame_no++;
    check_eq("wrap_tick_cap", 32'(bus.board_ready), 32'd0);
    push_frame(18'h20000, 1'b1, 1'b1, -1);
    wait_frame(n);
    check_eq("ready_rise2", 32'(bus.board_ready), 32'd1);

    // X at centre with cursor on it; four frames of it.
    push_frame(18'h00100, 1'b0, 1'b0, blank_for(frame_no + 1));
    repeat (5) @(negedge clk);
    offer(18'h00100, 1'b0, 1'b0, 4'd5);
    for (int f = 0; f < 3; f++) begin
      wait_frame(n);
      push_frame(18'h00100, 1'b0, 1'b0, blank_for(frame_no + 1));
    end
    wait_frame(n);

    // Reset during row 5 with an update pending.
    repeat (3) @(negedge clk);
    offer(18'h00002, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 40; i++) begin
      if (dot_row == 10'h020) break;
      @(negedge clk);
    end
    check_eq("row5_reached", 32'(dot_row), 32'h020);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_dot_row", 32'(dot_row), 32'd0);
    check_eq("mid_rst_dot_col", 32'(dot_col), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.board_ready), 32'd1);
    check_eq("mid_rst_fs", 32'(frame_start), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    frame_no = 0;
    push_frame('0, 1'b0, 1'b0, -1);
    rst = 1'b0;
    wait_frame(n);
    check_eq("first_tick2", 32'(n), 32'(SD));
    push_frame('0, 1'b0, 1'b0, -1);
    wait_frame(n);
    repeat (38) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
